// File: rtl/spike_line_window_scheduler_pkg.sv
// Shared frame/kernel parameters and FSM encoding for the spike line window scheduler.
// SPIKE_WIN_ZERO_PAD_EN selects the zero-padded window count.
package spike_line_window_scheduler_pkg;

  localparam int unsigned IMG_WIDTH  = 32;
  localparam int unsigned TIME_STEPS = 4;
  localparam int unsigned IMG_HEIGHT = 32;
  localparam int unsigned KERNEL_H   = 3;
  // Power of two so slot pointers wrap naturally; must be >= KERNEL_H+1
  localparam int unsigned NUM_SLOTS  = 4;

  localparam int unsigned LINE_W = IMG_WIDTH * TIME_STEPS;
  localparam int unsigned SLOT_W = $clog2(NUM_SLOTS);
  localparam int unsigned OCC_W  = $clog2(NUM_SLOTS + 1);
  localparam int unsigned CNT_W  = 6;
  localparam int unsigned EXT_W  = CNT_W + 1;
  localparam int unsigned IDX_W  = 2;

`ifdef SPIKE_WIN_ZERO_PAD_EN
  localparam int unsigned NWIN = IMG_HEIGHT;
`else
  localparam int unsigned NWIN = IMG_HEIGHT - KERNEL_H + 1;
`endif

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WAIT    = 3'd1,
    ISSUE   = 3'd2,
    RELEASE = 3'd3,
    DONE    = 3'd4
  } sched_state_e;

endpackage

// File: rtl/spike_line_window_scheduler_ram.sv
// Line slot storage: NUM_SLOTS x LINE_W simple dual-port RAM with registered read.
module spike_line_ram
  import spike_line_window_scheduler_pkg::*;
(
  input  logic              s_clk,
  input  logic              wr_en,
  input  logic [SLOT_W-1:0] wr_addr,
  input  logic [LINE_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [SLOT_W-1:0] rd_addr,
  output logic [LINE_W-1:0] rd_data
);

  logic [LINE_W-1:0] mem [NUM_SLOTS];

  always_ff @(posedge s_clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/spike_line_window_scheduler.sv
// Ring-buffers incoming spike lines and replays them as KERNEL_H-row vertical windows.
// SPIKE_WIN_ZERO_PAD_EN adds one zero row above and below the frame.
module spike_line_window_scheduler
  import spike_line_window_scheduler_pkg::*;
(
  input  logic              s_clk,
  input  logic              s_rst,
  input  logic              i_frame_start,
  input  logic              i_line_valid,
  input  logic [LINE_W-1:0] i_line_data,
  output logic              o_buf_full,
  output logic              o_overflow,
  output logic              o_row_valid,
  input  logic              i_row_ready,
  output logic [LINE_W-1:0] o_row_data,
  output logic [1:0]        o_row_idx,
  output logic              o_row_last,
  output logic [5:0]        o_win_cnt,
  output logic              o_frame_done
);

  sched_state_e state_q, state_d;
  logic frame_done_d;

  logic [SLOT_W-1:0] wr_ptr_q, rd_ptr_q, rd_addr;
  logic [OCC_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  line_cnt_q, win_q;
  logic [EXT_W-1:0]  need_rows;
  logic [IDX_W-1:0]  fetch_q, q_idx_q;
  logic              q_vld_q, q_pad_q, q_last_q;
  logic [LINE_W-1:0] ram_rd_data;

  logic in_frame, wr_acc, ovf_evt, rows_ready, beat_acc, out_take, move, issue;
  logic pad_beat, rel_fire, frees;

  assign in_frame   = line_cnt_q < CNT_W'(IMG_HEIGHT);
  assign wr_acc     = i_line_valid && !o_buf_full && in_frame;
  assign ovf_evt    = i_line_valid && o_buf_full && in_frame;
  assign rows_ready = EXT_W'(line_cnt_q) >= need_rows;
  assign beat_acc   = o_row_valid && i_row_ready;
  assign out_take   = !o_row_valid || i_row_ready;
  assign move       = q_vld_q && out_take;
  // One read in flight ahead of the output register keeps beats back-to-back
  assign issue      = (state_q == ISSUE) && (fetch_q < IDX_W'(KERNEL_H)) && (!q_vld_q || move);
  assign rel_fire   = (state_q == RELEASE);
  assign occ_d      = occ_q + OCC_W'(wr_acc) - OCC_W'(frees);

`ifdef SPIKE_WIN_ZERO_PAD_EN
  // Window w spans real rows w-1..w+1; rows outside the frame are zero beats
  assign need_rows = (EXT_W'(win_q) + EXT_W'(KERNEL_H - 1) > EXT_W'(IMG_HEIGHT)) ?
                     EXT_W'(IMG_HEIGHT) : EXT_W'(win_q) + EXT_W'(KERNEL_H - 1);
  assign pad_beat  = ((win_q == '0) && (fetch_q == '0)) ||
                     (EXT_W'(win_q) + EXT_W'(fetch_q) > EXT_W'(IMG_HEIGHT));
  assign rd_addr   = rd_ptr_q + SLOT_W'(fetch_q) - SLOT_W'(win_q == '0);
  assign frees     = rel_fire && (win_q != '0);
`else
  assign need_rows = EXT_W'(win_q) + EXT_W'(KERNEL_H);
  assign pad_beat  = 1'b0;
  assign rd_addr   = rd_ptr_q + SLOT_W'(fetch_q);
  assign frees     = rel_fire;
`endif

  spike_line_ram u_ram (
    .s_clk   (s_clk),
    .wr_en   (wr_acc && !i_frame_start),
    .wr_addr (wr_ptr_q),
    .wr_data (i_line_data),
    .rd_en   (issue && !pad_beat),
    .rd_addr (rd_addr),
    .rd_data (ram_rd_data)
  );

  // Frame sequencing
  always_comb begin
    state_d      = state_q;
    frame_done_d = 1'b0;
    case (state_q)
      IDLE:    if (i_frame_start) state_d = WAIT;
      WAIT:    if (rows_ready) state_d = ISSUE;
      ISSUE:   if (beat_acc && o_row_last) state_d = RELEASE;
      RELEASE: state_d = (win_q == CNT_W'(NWIN - 1)) ? DONE : WAIT;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (i_frame_start) state_d = WAIT;
    frame_done_d = (state_d == DONE);
  end

  always_ff @(posedge s_clk) begin
    if (s_rst) begin
      state_q      <= IDLE;
      o_frame_done <= 1'b0;
    end else begin
      state_q      <= state_d;
      o_frame_done <= frame_done_d;
    end
  end

  // Ring pointers, occupancy, read pipeline and beat output register
  always_ff @(posedge s_clk) begin
    if (s_rst || i_frame_start) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      occ_q       <= '0;
      o_buf_full  <= 1'b0;
      o_overflow  <= 1'b0;
      line_cnt_q  <= '0;
      win_q       <= '0;
      fetch_q     <= '0;
      q_vld_q     <= 1'b0;
      q_pad_q     <= 1'b0;
      q_idx_q     <= '0;
      q_last_q    <= 1'b0;
      o_row_valid <= 1'b0;
      o_row_data  <= '0;
      o_row_idx   <= '0;
      o_row_last  <= 1'b0;
      o_win_cnt   <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr_q   <= wr_ptr_q + SLOT_W'(1);
        line_cnt_q <= line_cnt_q + CNT_W'(1);
      end
      if (ovf_evt) o_overflow <= 1'b1;
      if (frees) rd_ptr_q <= rd_ptr_q + SLOT_W'(1);
      if (rel_fire) win_q <= win_q + CNT_W'(1);
      occ_q      <= occ_d;
      o_buf_full <= (occ_d == OCC_W'(NUM_SLOTS));

      if (state_q != ISSUE) fetch_q <= '0;
      else if (issue) fetch_q <= fetch_q + IDX_W'(1);

      if (issue) begin
        q_vld_q  <= 1'b1;
        q_pad_q  <= pad_beat;
        q_idx_q  <= fetch_q;
        q_last_q <= (fetch_q == IDX_W'(KERNEL_H - 1));
      end else if (move) begin
        q_vld_q <= 1'b0;
      end

      if (move) begin
        o_row_valid <= 1'b1;
        o_row_data  <= q_pad_q ? '0 : ram_rd_data;
        o_row_idx   <= q_idx_q;
        o_row_last  <= q_last_q;
        o_win_cnt   <= win_q;
      end else if (beat_acc) begin
        o_row_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_spike_line_window_scheduler.sv
// Directed self-checking bench for spike_line_window_scheduler (adapts to SPIKE_WIN_ZERO_PAD_EN).
module tb_spike_line_window_scheduler;

`ifdef SPIKE_WIN_ZERO_PAD_EN
  localparam int NWIN = 32;
  localparam int PAD  = 1;
`else
  localparam int NWIN = 30;
  localparam int PAD  = 0;
`endif

  typedef logic [136:0] beat_t;

  logic         s_clk, s_rst, i_frame_start, i_line_valid, i_row_ready;
  logic [127:0] i_line_data, o_row_data;
  logic         o_buf_full, o_overflow, o_row_valid, o_row_last, o_frame_done;
  logic [1:0]   o_row_idx;
  logic [5:0]   o_win_cnt;

  int    total = 0;
  int    bad   = 0;
  int    mode  = 0;
  int    done_cnt = 0;
  beat_t beats[$];

  spike_line_window_scheduler dut (
    .s_clk(s_clk), .s_rst(s_rst), .i_frame_start(i_frame_start),
    .i_line_valid(i_line_valid), .i_line_data(i_line_data),
    .o_buf_full(o_buf_full), .o_overflow(o_overflow),
    .o_row_valid(o_row_valid), .i_row_ready(i_row_ready),
    .o_row_data(o_row_data), .o_row_idx(o_row_idx), .o_row_last(o_row_last),
    .o_win_cnt(o_win_cnt), .o_frame_done(o_frame_done)
  );

  initial begin
    s_clk = 1'b0;
    forever #5 s_clk = ~s_clk;
  end

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] lp(input int f, input int i);
    logic [31:0] w;
    w = 32'(i) | (32'(f) << 8) | 32'hA000_0000;
    return {w, ~w, w ^ 32'h0F0F_0F0F, w + 32'd7};
  endfunction

  function automatic beat_t exp_beat(input int f, input int w, input int k);
    int row;
    logic [127:0] d;
    row = w + k - PAD;
    d   = (row < 0 || row >= 32) ? 128'd0 : lp(f, row);
    return {6'(w), 2'(k), (k == 2), d};
  endfunction

  // Collects accepted beats and frame-done pulses; verifies held beats stay stable
  logic  stall_q = 1'b0;
  logic  fs_q    = 1'b1;
  beat_t held_q;
  always @(negedge s_clk) begin
    if (stall_q && !fs_q) begin
      chk("stall_valid", 256'(o_row_valid), 256'(1));
      chk("stall_hold", 256'({o_win_cnt, o_row_idx, o_row_last, o_row_data}), 256'(held_q));
    end
    if (!s_rst && o_row_valid && i_row_ready) beats.push_back({o_win_cnt, o_row_idx, o_row_last, o_row_data});
    if (!s_rst && o_frame_done) done_cnt++;
    stall_q = o_row_valid && !i_row_ready;
    held_q  = {o_win_cnt, o_row_idx, o_row_last, o_row_data};
    fs_q    = i_frame_start || s_rst;
  end

  task automatic tick();
    @(posedge s_clk);
    #1;
    i_line_valid  = 1'b0;
    i_frame_start = 1'b0;
    case (mode)
      0: i_row_ready = 1'b1;
      1: i_row_ready = 1'b0;
      2: i_row_ready = ~i_row_ready;
      default: ;
    endcase
  endtask

  task automatic send_line(input int f, input int i);
    i_line_valid = 1'b1;
    i_line_data  = lp(f, i);
    tick();
  endtask

  task automatic start_frame();
    beats.delete();
    i_frame_start = 1'b1;
    tick();
  endtask

  task automatic run_frame(input int f, input int gap, input int abort_win, output bit aborted);
    int i;
    i = 0;
    aborted = 1'b0;
    for (int cyc = 0; cyc < 32 * gap; cyc++) begin
      if (abort_win >= 0 && o_row_valid && o_row_idx == 2'd1 && o_win_cnt == 6'(abort_win)) begin
        i_frame_start = 1'b1;
        tick();
        aborted = 1'b1;
        return;
      end
      if (cyc % gap == 0) begin
        i_line_valid = 1'b1;
        i_line_data  = lp(f, i);
        i++;
      end
      tick();
    end
  endtask

  task automatic wait_done(input string tag, input int start);
    int n;
    n = 0;
    while (done_cnt == start && n < 400) begin
      tick();
      n++;
    end
    repeat (5) tick();
    chk(tag, 256'(done_cnt - start), 256'(1));
  endtask

  task automatic check_beats(input string tag, input int f, input int nexp);
    chk({tag, "_count"}, 256'(beats.size()), 256'(nexp));
    for (int j = 0; j < nexp && j < beats.size(); j++)
      chk($sformatf("%s_beat%0d", tag, j), 256'(beats[j]), 256'(exp_beat(f, j / 3, j % 3)));
  endtask

  initial begin
    bit ab;
    bit found;
    int d0;
    s_rst = 1'b1; i_frame_start = 1'b0; i_line_valid = 1'b0;
    i_line_data = '0; i_row_ready = 1'b1;

    // Reset state
    repeat (3) tick();
    chk("rst_outputs", 256'({o_buf_full, o_overflow, o_row_valid, o_row_data, o_row_idx,
                             o_row_last, o_win_cnt, o_frame_done}), 256'(0));
    s_rst = 1'b0;
    repeat (4) tick();
    chk("idle_outputs", 256'({o_buf_full, o_overflow, o_row_valid, o_frame_done}), 256'(0));

    // Full frame, always ready
    mode = 0;
    start_frame();
    d0 = done_cnt;
    run_frame(1, 12, -1, ab);
    wait_done("f1_done_once", d0);
    check_beats("f1", 1, NWIN * 3);
    chk("f1_overflow", 256'(o_overflow), 256'(0));
    chk("f1_valid_end", 256'(o_row_valid), 256'(0));

    // Stalled window 0 while lines keep arriving: fill, drop, overflow
    mode = 1;
    start_frame();
    d0 = done_cnt;
    for (int i = 0; i < 5; i++) send_line(2, i);
    repeat (40) tick();
    chk("f2_full", 256'(o_buf_full), 256'(1));
    chk("f2_overflow", 256'(o_overflow), 256'(1));
    chk("f2_valid", 256'(o_row_valid), 256'(1));
    chk("f2_head", 256'({o_win_cnt, o_row_idx, o_row_last, o_row_data}), 256'(exp_beat(2, 0, 0)));
    mode = 0;
    repeat (40) tick();
    chk("f2_overflow_sticky", 256'(o_overflow), 256'(1));
    check_beats("f2", 2, (PAD != 0) ? 9 : 6);
    start_frame();
    chk("f2_clear", 256'({o_overflow, o_buf_full, o_row_valid}), 256'(0));
    chk("f2_no_done", 256'(done_cnt - d0), 256'(0));

    // Abort at window 10 beat 1
    d0 = done_cnt;
    run_frame(3, 12, 10, ab);
    chk("f3_aborted", 256'(ab), 256'(1));
    chk("f3_valid_drop", 256'(o_row_valid), 256'(0));
    check_beats("f3", 3, 32);
    beats.delete();

    // Next frame from window 0 with ready toggling every cycle
    mode = 2;
    run_frame(4, 16, -1, ab);
    wait_done("f4_done_once", d0);
    check_beats("f4", 4, NWIN * 3);

    // Line write landing on the release cycle at occupancy 3
    mode = 0;
    start_frame();
    for (int i = 0; i < 3; i++) send_line(5, i);
    found = 1'b0;
    for (int n = 0; n < 300 && !found; n++) begin
      if (o_row_valid && o_row_last && i_row_ready && o_win_cnt == 6'(PAD)) found = 1'b1;
      else tick();
    end
    chk("f5_found_release", 256'(found), 256'(1));
    tick();
    mode = 1;
    send_line(5, 3);
    chk("f5_same_cycle_full", 256'({o_buf_full, o_overflow}), 256'(0));
    send_line(5, 4);
    chk("f5_fourth_full", 256'({o_buf_full, o_overflow}), 256'({1'b1, 1'b0}));
    send_line(5, 5);
    chk("f5_overflow", 256'({o_buf_full, o_overflow}), 256'({1'b1, 1'b1}));
    mode = 0;
    start_frame();
    chk("f5_clear", 256'({o_overflow, o_buf_full, o_row_valid}), 256'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
